pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controls the 64-bit program-counter register (Reg_64S, ports D/Stall/Q) in the pipelined ARMv8 core.
- Each cycle it computes the next PC (pc_d) and the register's Stall (pc_stall), choosing between reset vector, sequential fetch, branch redirect and exception redirect.
- Arbitrates the competing stall and redirect sources, inserts a fixed refill penalty after redirects, and generates the IF/ID and ID/EX flush controls.

Parameters:
- RESET_VECTOR, 64'h0, PC value loaded in the first cycle after reset.
- PC_STEP, 4, sequential increment in bytes.
- FLUSH_CYCLES, 2, refill cycles spent in FLUSH after a redirect; legal range is 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- pc_q  in  64  current PC (Q of the PC register).
- imem_ready  in  1  instruction memory can accept a fetch this cycle.
- hazard_stall  in  1  load-use hazard request from ID.
- br_taken  in  1  taken branch resolved in EX.
- br_target  in  64  branch target address.
- exc_req  in  1  exception request.
- exc_vector  in  64  exception handler address.
- pc_d  out  64  next-PC value, driven to D of the PC register.
- pc_stall  out  1  Stall of the PC register.
- fetch_valid  out  1  the instruction fetched this cycle is valid.
- if_id_flush  out  1  squash the IF/ID pipeline register.
- id_ex_flush  out  1  squash the ID/EX pipeline register (inject a bubble).
- exc_ack  out  1  one-cycle acknowledge that an exception redirect was taken.
- redirect_count  out  16  number of redirects taken; wraps modulo 2^16.
- state  out  2  debug: BOOT=0, RUN=1, WAIT_MEM=2, FLUSH=3.

Behaviour:
- Reset low, asynchronously: state=BOOT, flush counter=0, redirect_count=0.
- pc_d, pc_stall, fetch_valid, the flushes and exc_ack are combinational from state and inputs. The PC register supplies the one-cycle latency.
- Default values: pc_stall=1, pc_d=pc_q, all other control outputs 0.
- Redirect priority, from highest: exc_req, then br_taken, then hazard_stall, then !imem_ready, then sequential fetch.
- Redirect action (exception or branch):
  - pc_d = exc_vector or br_target; pc_stall=0.
  - if_id_flush=1, id_ex_flush=1.
  - exc_ack=1 for exceptions only.
  - redirect_count += 1.
  - Next state FLUSH, counter loaded with FLUSH_CYCLES.
- BOOT: pc_d=RESET_VECTOR, pc_stall=0, fetch_valid=0; all requests are ignored; next state RUN.
- RUN:
  - Redirect if exc_req or br_taken.
  - Else if hazard_stall: pc_stall=1, id_ex_flush=1, fetch_valid=0; stay in RUN.
  - Else if !imem_ready: pc_stall=1, fetch_valid=0; go to WAIT_MEM.
  - Else: pc_d=pc_q+PC_STEP, pc_stall=0, fetch_valid=1.
- WAIT_MEM:
  - Redirects are honoured with the same priority as in RUN.
  - hazard_stall is ignored, because no new instruction is being decoded.
  - While imem_ready=0: hold pc_stall=1.
  - When imem_ready=1: pc_d=pc_q+PC_STEP, pc_stall=0, fetch_valid=1; go to RUN.
- FLUSH:
  - pc_stall=1, fetch_valid=0, if_id_flush=1; the counter decrements each cycle.
  - Leave for RUN in the cycle the counter reaches 1 (after exactly FLUSH_CYCLES cycles).
  - exc_req is honoured and restarts FLUSH with a fresh count.
  - br_taken and hazard_stall are ignored, since they belong to a squashed path.
- Arithmetic: pc_q+PC_STEP wraps modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 gives 0.
- Simultaneous exc_req and br_taken: the exception wins and is the only redirect counted.
- Reset asserted mid-FLUSH or mid-WAIT_MEM: the block returns to BOOT immediately and the flush counter clears.
- Unreachable state encodings recover to BOOT on the next clock.

Test Plan:
- Reset low, then release with imem_ready=1: cycle 1 gives pc_d=0, state BOOT. Following cycles give pc_d=4, 8, 12 with fetch_valid=1.
- With pc_q=0x100, pulse hazard_stall for 2 cycles: pc_stall=1 and id_ex_flush=1 for both cycles; pc_d=0x104 resumes afterwards.
- With pc_q=0x200, drop imem_ready for 3 cycles: state=WAIT_MEM and pc_stall=1 for 3 cycles. The cycle imem_ready rises gives pc_d=0x204, fetch_valid=1.
- br_taken with br_target=0x400 and exc_req with exc_vector=0x800 in the same RUN cycle: pc_d=0x800, exc_ack=1, both flushes asserted, redirect_count=1. FLUSH then lasts 2 cycles before RUN resumes with pc_d=0x804.
- br_taken asserted during FLUSH is ignored. exc_req with exc_vector=0x900 during FLUSH gives pc_d=0x900 and restarts a 2-cycle FLUSH.
- Assert Reset in the middle of FLUSH: state=BOOT immediately, redirect_count=0. The next cycle after release gives pc_d=RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and the core: PC register feedback, fetch/hazard/redirect
// requests in; next-PC, stall, flush and debug signals out.
interface pc_sequencer_if;
  logic [63:0] pc_q;
  logic        imem_ready;
  logic        hazard_stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        exc_req;
  logic [63:0] exc_vector;
  logic [63:0] pc_d;
  logic        pc_stall;
  logic        fetch_valid;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        exc_ack;
  logic [15:0] redirect_count;
  logic [1:0]  state;

  // valid/ready: a fetch completes only in a cycle where imem_ready=1 and fetch_valid=1;
  // redirect requests are level-sampled each cycle and need no ready.
  modport slave (
    input  pc_q, imem_ready, hazard_stall, br_taken, br_target, exc_req, exc_vector,
    output pc_d, pc_stall, fetch_valid, if_id_flush, id_ex_flush, exc_ack,
           redirect_count, state
  );

  modport master (
    output pc_q, imem_ready, hazard_stall, br_taken, br_target, exc_req, exc_vector,
    input  pc_d, pc_stall, fetch_valid, if_id_flush, id_ex_flush, exc_ack,
           redirect_count, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection and stall/flush control for the 64-bit program-counter register.
// Outputs are combinational from state and inputs; the PC register supplies the latency.
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          PC_STEP      = 4,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, WAIT_MEM = 2'd2, FLUSH = 2'd3} state_t;

    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [63:0] STEP       = 64'(PC_STEP);

    state_t      state_q, state_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [15:0] rcount_q;
    logic        redir_exc, redir_br;
    logic [63:0] pc_d;
    logic        pc_stall, fetch_valid, if_id_flush, id_ex_flush, exc_ack;

    always_comb begin
        pc_d        = bus.pc_q;
        pc_stall    = 1'b1;
        fetch_valid = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        exc_ack     = 1'b0;
        redir_exc   = 1'b0;
        redir_br    = 1'b0;
        state_n     = state_q;
        cnt_n       = cnt_q;
        case (state_q)
            BOOT: begin
                pc_d     = RESET_VECTOR;
                pc_stall = 1'b0;
                state_n  = RUN;
            end
            RUN: begin
                if (bus.exc_req)           redir_exc = 1'b1;
                else if (bus.br_taken)     redir_br  = 1'b1;
                else if (bus.hazard_stall) id_ex_flush = 1'b1;
                else if (!bus.imem_ready)  state_n = WAIT_MEM;
                else begin
                    pc_d        = bus.pc_q + STEP;
                    pc_stall    = 1'b0;
                    fetch_valid = 1'b1;
                end
            end
            WAIT_MEM: begin
                // hazard_stall is not consulted: nothing new is in decode
                if (bus.exc_req)       redir_exc = 1'b1;
                else if (bus.br_taken) redir_br  = 1'b1;
                else if (bus.imem_ready) begin
                    pc_d        = bus.pc_q + STEP;
                    pc_stall    = 1'b0;
                    fetch_valid = 1'b1;
                    state_n     = RUN;
                end
            end
            FLUSH: begin
                // branches and hazards here come from the squashed path
                if_id_flush = 1'b1;
                if (bus.exc_req) redir_exc = 1'b1;
                else if (cnt_q <= 4'd1) begin
                    cnt_n   = 4'd0;
                    state_n = RUN;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            default: state_n = BOOT;
        endcase

        if (redir_exc || redir_br) begin
            pc_d        = redir_exc ? bus.exc_vector : bus.br_target;
            pc_stall    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            exc_ack     = redir_exc;
            state_n     = FLUSH;
            cnt_n       = FLUSH_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            cnt_q    <= 4'd0;
            rcount_q <= 16'd0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            if (redir_exc || redir_br) rcount_q <= rcount_q + 16'd1;
        end
    end

    assign bus.pc_d           = pc_d;
    assign bus.pc_stall       = pc_stall;
    assign bus.fetch_valid    = fetch_valid;
    assign bus.if_id_flush    = if_id_flush;
    assign bus.id_ex_flush    = id_ex_flush;
    assign bus.exc_ack        = exc_ack;
    assign bus.redirect_count = rcount_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle-by-cycle vector table driven open-loop on pc_q,
// followed by hand-written reset-in-flight sequences.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VECTOR(64'h0), .PC_STEP(4), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc_q;
    logic        imem, haz, br;
    logic [63:0] br_tgt;
    logic        exc;
    logic [63:0] exc_vec;
    logic [63:0] e_pc_d;
    logic        e_stall, e_fv, e_ifid, e_idex, e_ack;
    logic [15:0] e_rc;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic add(input logic [63:0] pcq, input logic im, input logic hz, input logic b,
                     input logic [63:0] bt, input logic e, input logic [63:0] ev,
                     input logic [63:0] pd, input logic st, input logic fv, input logic f1,
                     input logic f2, input logic ak, input logic [15:0] rc, input logic [1:0] s);
    vec_t v;
    v.pc_q = pcq; v.imem = im; v.haz = hz; v.br = b; v.br_tgt = bt; v.exc = e; v.exc_vec = ev;
    v.e_pc_d = pd; v.e_stall = st; v.e_fv = fv; v.e_ifid = f1; v.e_idex = f2; v.e_ack = ak;
    v.e_rc = rc; v.e_st = s;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] pcq, input logic im, input logic hz, input logic b,
                       input logic [63:0] bt, input logic e, input logic [63:0] ev);
    bus.pc_q = pcq; bus.imem_ready = im; bus.hazard_stall = hz;
    bus.br_taken = b; bus.br_target = bt; bus.exc_req = e; bus.exc_vector = ev;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".pc_d"},        bus.pc_d,           v.e_pc_d);
    chk({tag, ".pc_stall"},    64'(bus.pc_stall),    64'(v.e_stall));
    chk({tag, ".fetch_valid"}, 64'(bus.fetch_valid), 64'(v.e_fv));
    chk({tag, ".if_id_flush"}, 64'(bus.if_id_flush), 64'(v.e_ifid));
    chk({tag, ".id_ex_flush"}, 64'(bus.id_ex_flush), 64'(v.e_idex));
    chk({tag, ".exc_ack"},     64'(bus.exc_ack),     64'(v.e_ack));
    chk({tag, ".redirect_count"}, 64'(bus.redirect_count), 64'(v.e_rc));
    chk({tag, ".state"},       64'(bus.state),       64'(v.e_st));
  endtask

  initial begin
    //   pc_q                    im hz br br_tgt   ex exc_vec  | pc_d       st fv f1 f2 ak rc st
    add(64'h0,                  1, 0, 1, 64'h40,  0, 64'h0,   64'h0,     0, 0, 0, 0, 0, 0, 0);
    add(64'h0,                  1, 0, 0, 64'h0,   0, 64'h0,   64'h4,     0, 1, 0, 0, 0, 0, 1);
    add(64'h4,                  1, 0, 0, 64'h0,   0, 64'h0,   64'h8,     0, 1, 0, 0, 0, 0, 1);
    add(64'h8,                  1, 0, 0, 64'h0,   0, 64'h0,   64'hC,     0, 1, 0, 0, 0, 0, 1);
    add(64'h100,                1, 1, 0, 64'h0,   0, 64'h0,   64'h100,   1, 0, 0, 1, 0, 0, 1);
    add(64'h100,                1, 1, 0, 64'h0,   0, 64'h0,   64'h100,   1, 0, 0, 1, 0, 0, 1);
    add(64'h100,                1, 0, 0, 64'h0,   0, 64'h0,   64'h104,   0, 1, 0, 0, 0, 0, 1);
    add(64'h200,                0, 0, 0, 64'h0,   0, 64'h0,   64'h200,   1, 0, 0, 0, 0, 0, 1);
    add(64'h200,                0, 1, 0, 64'h0,   0, 64'h0,   64'h200,   1, 0, 0, 0, 0, 0, 2);
    add(64'h200,                0, 0, 0, 64'h0,   0, 64'h0,   64'h200,   1, 0, 0, 0, 0, 0, 2);
    add(64'h200,                1, 0, 0, 64'h0,   0, 64'h0,   64'h204,   0, 1, 0, 0, 0, 0, 2);
    add(64'h300,                1, 0, 1, 64'h400, 1, 64'h800, 64'h800,   0, 0, 1, 1, 1, 0, 1);
    add(64'h800,                1, 0, 1, 64'h400, 0, 64'h0,   64'h800,   1, 0, 1, 0, 0, 1, 3);
    add(64'h800,                1, 1, 0, 64'h0,   0, 64'h0,   64'h800,   1, 0, 1, 0, 0, 1, 3);
    add(64'h800,                1, 0, 0, 64'h0,   0, 64'h0,   64'h804,   0, 1, 0, 0, 0, 1, 1);
    add(64'h804,                1, 0, 1, 64'h400, 0, 64'h0,   64'h400,   0, 0, 1, 1, 0, 1, 1);
    add(64'h400,                1, 0, 0, 64'h0,   1, 64'h900, 64'h900,   0, 0, 1, 1, 1, 2, 3);
    add(64'h900,                1, 0, 0, 64'h0,   0, 64'h0,   64'h900,   1, 0, 1, 0, 0, 3, 3);
    add(64'h900,                1, 0, 0, 64'h0,   0, 64'h0,   64'h900,   1, 0, 1, 0, 0, 3, 3);
    add(64'h900,                1, 0, 0, 64'h0,   0, 64'h0,   64'h904,   0, 1, 0, 0, 0, 3, 1);
    add(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 64'h0,  0, 64'h0,   64'h0,     0, 1, 0, 0, 0, 3, 1);
    add(64'h1000,               0, 0, 0, 64'h0,   0, 64'h0,   64'h1000,  1, 0, 0, 0, 0, 3, 1);
    add(64'h1000,               0, 0, 0, 64'h0,   1, 64'hA00, 64'hA00,   0, 0, 1, 1, 1, 3, 2);
    add(64'hA00,                1, 0, 0, 64'h0,   0, 64'h0,   64'hA00,   1, 0, 1, 0, 0, 4, 3);
    add(64'hA00,                1, 0, 0, 64'h0,   0, 64'h0,   64'hA00,   1, 0, 1, 0, 0, 4, 3);

    rst_n = 1'b0;
    drive(64'h0, 1, 0, 0, 64'h0, 0, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.state", 64'(bus.state), 64'd0);
    chk("reset.redirect_count", 64'(bus.redirect_count), 64'd0);
    chk("reset.pc_d", bus.pc_d, 64'h0);
    rst_n = 1'b1;

    // table: each iteration starts on a negedge, checks before the next posedge
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pc_q, vecs[i].imem, vecs[i].haz, vecs[i].br,
            vecs[i].br_tgt, vecs[i].exc, vecs[i].exc_vec);
      #2;
      chk_all($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // reset asserted in the middle of FLUSH
    drive(64'h1004, 1, 0, 1, 64'h500, 0, 64'h0);
    #2;
    chk("seqA.br_pc_d", bus.pc_d, 64'h500);
    @(negedge clk);
    drive(64'h500, 1, 0, 0, 64'h0, 0, 64'h0);
    #2;
    chk("seqA.in_flush", 64'(bus.state), 64'd3);
    chk("seqA.rc_before", 64'(bus.redirect_count), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("seqA.rst_state", 64'(bus.state), 64'd0);
    chk("seqA.rst_rc", 64'(bus.redirect_count), 64'd0);
    chk("seqA.rst_pc_d", bus.pc_d, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("seqA.boot_pc_d", bus.pc_d, 64'h0);
    chk("seqA.boot_fv", 64'(bus.fetch_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("seqA.run_state", 64'(bus.state), 64'd1);
    chk("seqA.run_pc_d", bus.pc_d, 64'h504);
    chk("seqA.run_fv", 64'(bus.fetch_valid), 64'd1);

    // reset asserted in the middle of WAIT_MEM
    bus.imem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("seqB.wait_state", 64'(bus.state), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("seqB.rst_state", 64'(bus.state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    #2;
    chk("seqB.boot_state", 64'(bus.state), 64'd0);
    @(negedge clk);
    #2;
    chk("seqB.run_state", 64'(bus.state), 64'd1);
    chk("seqB.run_pc_d", bus.pc_d, 64'h504);
    chk("seqB.run_rc", 64'(bus.redirect_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
